// File: rtl/count_cmd_sequencer.sv
// count_cmd_sequencer
//   Accepts one command at a time (NOP, LOAD, RUN, reserved) and drives the
//   load/enable/start_val inputs of a downstream 5-bit rollover counter.
//   After every command there is a single FIN cycle with a done pulse, and
//   aborted/err qualify that pulse.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present on cmd_op/cmd_arg
//   cmd_ready  block can accept a command this cycle (IDLE and out of reset)
//   cmd_op     00 NOP, 01 LOAD, 10 RUN, 11 reserved
//   cmd_arg    LOAD value, or RUN cycle count (0 means 32)
//   abort      terminates a RUN in progress, ignored otherwise
//   load       counter load strobe (one cycle per LOAD)
//   enable     counter enable (high for each RUN cycle)
//   start_val  counter start value, holds the last loaded value
//   busy       command in progress
//   done       one-cycle completion pulse
//   aborted    with done, RUN ended by abort
//   err        with done, reserved op was issued
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | load strobe cycle
// RUN   | counter enabled, r_remain cycles left including this one
// FIN   | one-cycle completion, done (plus aborted/err) high

module count_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_arg,
  input  logic       abort,
  output logic       load,
  output logic       enable,
  output logic [4:0] start_val,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  // 6 bits so that a RUN of 32 cycles fits without wrapping
  logic [5:0] r_remain;
  logic [5:0] w_remain_nxt;

  logic       r_load,      w_load_nxt;
  logic       r_enable,    w_enable_nxt;
  logic [4:0] r_start_val, w_start_val_nxt;
  logic       r_busy,      w_busy_nxt;
  logic       r_done,      w_done_nxt;
  logic       r_aborted,   w_aborted_nxt;
  logic       r_err,       w_err_nxt;

  logic       w_hs;

  assign cmd_ready = (r_state == ST_IDLE) && rst_n;
  assign w_hs      = cmd_valid && cmd_ready;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remain    <= 6'd0;
      r_load      <= 1'b0;
      r_enable    <= 1'b0;
      r_start_val <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_load      <= w_load_nxt;
      r_enable    <= w_enable_nxt;
      r_start_val <= w_start_val_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_aborted   <= w_aborted_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          case (cmd_op)
            OP_LOAD: w_state_nxt = ST_LOAD;
            OP_RUN: begin
              w_state_nxt  = ST_RUN;
              w_remain_nxt = (cmd_arg == 5'd0) ? 6'd32 : {1'b0, cmd_arg};
            end
            // NOP and reserved go straight to the completion cycle
            default: w_state_nxt = ST_FIN;
          endcase
        end
      end
      ST_LOAD: w_state_nxt = ST_FIN;
      ST_RUN: begin
        // abort wins even on the edge that ends the final cycle
        if (abort || (r_remain == 6'd1)) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_remain_nxt = r_remain - 6'd1;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    w_load_nxt      = (w_state_nxt == ST_LOAD);
    w_enable_nxt    = (w_state_nxt == ST_RUN);
    w_start_val_nxt = w_load_nxt ? cmd_arg : r_start_val;
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_done_nxt      = (w_state_nxt == ST_FIN);
    w_aborted_nxt   = (r_state == ST_RUN) && abort;
    w_err_nxt       = w_hs && (cmd_op == OP_RSVD);
  end

  assign load      = r_load;
  assign enable    = r_enable;
  assign start_val = r_start_val;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign err       = r_err;

endmodule

// File: doc/count_cmd_sequencer.md
COUNT_CMD_SEQUENCER -- requirements
Module: count_cmd_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command present on cmd_op/cmd_arg.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  2  00 NOP, 01 LOAD, 10 RUN, 11 reserved.
REQ-007 cmd_arg  input  5  LOAD: value to load; RUN: cycle count (0 means 32).
REQ-008 abort  input  1  terminate a RUN in progress.
REQ-009 load  output  1  drives the downstream 5-bit rollover counter load input.
REQ-010 enable  output  1  drives the downstream counter enable input.
REQ-011 start_val  output  5  drives the downstream counter start_val input.
REQ-012 busy  output  1  command in progress (state != IDLE).
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 aborted  output  1  one-cycle pulse, coincident with done, when RUN ended by abort.
REQ-015 err  output  1  one-cycle pulse, coincident with done, for reserved op 11.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN, FIN; load, enable, start_val, busy, done, aborted, err SHALL be registered outputs.
REQ-017 cmd_ready SHALL equal (state==IDLE) and rst_n; handshake occurs on a rising edge with cmd_valid and cmd_ready both high.
REQ-018 cmd_op/cmd_arg SHALL be captured only at handshake; changes while cmd_ready is low SHALL have no effect.
REQ-019 LOAD accepted at edge k: load=1 and start_val=cmd_arg from edge k to edge k+1; state goes to FIN at k+1.
REQ-020 start_val SHALL hold the last loaded value until the next LOAD; load SHALL never be high for more than one cycle per command.
REQ-021 RUN accepted at edge k with arg N (N=0 means 32): enable=1 for exactly N consecutive cycles starting at edge k; state goes to FIN after the Nth cycle.
REQ-022 The RUN remaining-cycle counter SHALL be 6 bits to represent 32 without overflow.
REQ-023 abort sampled high at an edge while in RUN: enable SHALL be 0 from that edge; state goes to FIN; aborted=1 in the FIN cycle.
REQ-024 abort sampled on the edge at which the final RUN cycle completes SHALL still set aborted; abort outside RUN SHALL be ignored.
REQ-025 NOP and reserved op: state goes to FIN at the next edge with no load or enable activity; reserved op additionally sets err in the FIN cycle.
REQ-026 FIN SHALL last exactly one cycle with done=1; the next state SHALL be IDLE.
REQ-027 busy SHALL be 1 in LOAD, RUN and FIN; load and enable SHALL never be high simultaneously.
REQ-028 Minimum command spacing SHALL be one IDLE cycle after each FIN.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and set load, enable, busy, done, aborted, err to 0 and start_val to 5'd0; cmd_ready SHALL be 0 while rst_n is low.
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL drop load/enable asynchronously, with no done pulse; the command is discarded.
REQ-031 The first edge after rst_n rises SHALL be able to accept a command.

Verification
REQ-032 Reset: rst_n=0 with cmd_valid=1 -> cmd_ready=0 and all outputs 0; release, LOAD arg 5'h08 -> load high for one cycle with start_val=8, then done pulse, then counter count==8.
REQ-033 RUN arg 5 after LOAD 0 -> enable high exactly 5 cycles; done on the 6th cycle; counter count==5 and holds.
REQ-034 RUN arg 0 after LOAD 5'h1F -> enable high 32 cycles; counter wraps 31->0 and ends at 31; done pulse once.
REQ-035 RUN arg 10 with abort at the 3rd enable cycle -> enable low from that edge; done and aborted pulse together; counter advanced by 3.
REQ-036 Reserved op 11 -> no load or enable; done and err pulse together; cmd_valid held high during busy -> no extra command accepted.
REQ-037 rst_n pulled low mid-RUN arg 20 -> enable drops immediately with no done; after release, a new LOAD is accepted normally.
